// File: rtl/clock_pkg.sv
// Shared types and field limits for the digital clock time-setting path.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_EDIT_H,
    ST_EDIT_M,
    ST_EDIT_S,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

endpackage

// File: rtl/time_set_ctrl_blink_gen.sv
// Blink generator: square wave of BLINK_HALF-cycle halves, held at 1 when disabled.
module blink_gen #(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic blink
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_blink;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_blink <= 1'b1;
    end else if (!en || restart) begin
      r_cnt   <= '0;
      r_blink <= 1'b1;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign blink = r_blink;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting UI: MODE steps through hour/min/sec edit, INC/DEC adjust, commit loads the timekeeper.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_HALF  = 25_000_000,
  parameter int TIMEOUT_SEC = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_pulse,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  output logic              edit_active,
  output logic [1:0]        edit_field,
  output logic [HOUR_W-1:0] set_hour,
  output logic [MIN_W-1:0]  set_min,
  output logic [SEC_W-1:0]  set_sec,
  output logic              load_pulse,
  output logic              blink
);

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_SEC - 1);

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  state_t            r_state, w_next;
  logic [3:0]        r_tmo, w_tmo_next;
  logic [HOUR_W-1:0] r_hour, w_hour_next;
  logic [MIN_W-1:0]  r_min, w_min_next;
  logic [SEC_W-1:0]  r_sec, w_sec_next;
  logic              r_edit_active, r_load;
  logic [1:0]        r_field, w_field_next;
  logic              w_restart, w_next_edit, w_key, w_adj_inc, w_adj_dec;

  assign w_key     = mode_pulse | inc_pulse | dec_pulse;
  assign w_adj_inc = inc_pulse & ~dec_pulse & ~mode_pulse;
  assign w_adj_dec = dec_pulse & ~inc_pulse & ~mode_pulse;

  always_comb begin
    w_next      = r_state;
    w_tmo_next  = r_tmo;
    w_hour_next = r_hour;
    w_min_next  = r_min;
    w_sec_next  = r_sec;
    w_restart   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mode_pulse) begin
          w_next      = ST_EDIT_H;
          w_hour_next = cur_hour;
          w_min_next  = cur_min;
          w_sec_next  = cur_sec;
          w_tmo_next  = 4'd0;
          w_restart   = 1'b1;
        end
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        // Key activity beats a coincident tick; timeout exits without a load.
        if (w_key) begin
          w_tmo_next = 4'd0;
        end else if (tick_1hz) begin
          if (r_tmo == TMO_LAST) begin
            w_next     = ST_RUN;
            w_tmo_next = 4'd0;
          end else begin
            w_tmo_next = r_tmo + 4'd1;
          end
        end
        if (inc_pulse || dec_pulse) w_restart = 1'b1;
        if (mode_pulse) begin
          case (r_state)
            ST_EDIT_H: w_next = ST_EDIT_M;
            ST_EDIT_M: w_next = ST_EDIT_S;
            default:   w_next = ST_COMMIT;
          endcase
        end else if (w_adj_inc || w_adj_dec) begin
          case (r_state)
            ST_EDIT_H: w_hour_next = w_adj_inc ? 5'(wrap_inc({1'b0, r_hour}, HOUR_MAX))
                                               : 5'(wrap_dec({1'b0, r_hour}, HOUR_MAX));
            ST_EDIT_M: w_min_next  = w_adj_inc ? wrap_inc(r_min, MIN_MAX) : wrap_dec(r_min, MIN_MAX);
            default:   w_sec_next  = w_adj_inc ? wrap_inc(r_sec, SEC_MAX) : wrap_dec(r_sec, SEC_MAX);
          endcase
        end
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_field_next = FIELD_NONE;
    w_next_edit  = 1'b1;
    case (w_next)
      ST_EDIT_H: w_field_next = FIELD_HOUR;
      ST_EDIT_M: w_field_next = FIELD_MIN;
      ST_EDIT_S: w_field_next = FIELD_SEC;
      default:   w_next_edit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_tmo         <= 4'd0;
      r_hour        <= '0;
      r_min         <= '0;
      r_sec         <= '0;
      r_edit_active <= 1'b0;
      r_field       <= FIELD_NONE;
      r_load        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_tmo         <= w_tmo_next;
      r_hour        <= w_hour_next;
      r_min         <= w_min_next;
      r_sec         <= w_sec_next;
      r_edit_active <= w_next_edit;
      r_field       <= w_field_next;
      r_load        <= (w_next == ST_COMMIT);
    end
  end

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .en      (w_next_edit),
    .restart (w_restart),
    .blink   (blink)
  );

  assign edit_active = r_edit_active;
  assign edit_field  = r_field;
  assign set_hour    = r_hour;
  assign set_min     = r_min;
  assign set_sec     = r_sec;
  assign load_pulse  = r_load;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed UI sequences plus random key traffic against a behavioural model.
module tb_time_set_ctrl;

  localparam int BH  = 1000;
  localparam int TMO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_pulse = 1'b0, inc_pulse = 1'b0, dec_pulse = 1'b0, tick_1hz = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic       edit_active, load_pulse, blink;
  logic [1:0] edit_field;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;

  int n_cmp = 0;
  int n_err = 0;

  // model: st 0=run, 1..3=editing that field, 4=commit cycle
  int m_st = 0, m_h = 0, m_m = 0, m_s = 0, m_tmo = 0, m_cyc = 0, m_bstart = 0;

  time_set_ctrl #(.BLINK_HALF(BH), .TIMEOUT_SEC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_pulse  (mode_pulse),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .tick_1hz    (tick_1hz),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .edit_active (edit_active),
    .edit_field  (edit_field),
    .set_hour    (set_hour),
    .set_min     (set_min),
    .set_sec     (set_sec),
    .load_pulse  (load_pulse),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit m, input bit i, input bit d, input bit t);
    m_cyc++;
    if (m_st == 0) begin
      if (m) begin
        m_st = 1; m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
        m_tmo = 0; m_bstart = m_cyc;
      end
    end else if (m_st == 4) begin
      m_st = 0;
    end else begin
      if (i || d) m_bstart = m_cyc;
      if (m) begin
        m_st = m_st + 1;
      end else if (i != d) begin
        case (m_st)
          1: m_h = i ? (m_h + 1) % 24 : (m_h + 23) % 24;
          2: m_m = i ? (m_m + 1) % 60 : (m_m + 59) % 60;
          default: m_s = i ? (m_s + 1) % 60 : (m_s + 59) % 60;
        endcase
      end
      if (m || i || d) m_tmo = 0;
      else if (t) begin
        m_tmo++;
        if (m_tmo >= TMO) begin m_st = 0; m_tmo = 0; end
      end
    end
  endtask

  task automatic compare_all();
    bit e;
    e = (m_st >= 1 && m_st <= 3);
    chk("edit_active", edit_active, e);
    chk("edit_field", edit_field, e ? m_st : 0);
    chk("load_pulse", load_pulse, m_st == 4);
    chk("blink", blink, e ? (((m_cyc - m_bstart) / BH) % 2 == 0) : 1);
    chk("set_hour", set_hour, m_h);
    chk("set_min", set_min, m_m);
    chk("set_sec", set_sec, m_s);
  endtask

  task automatic step(input bit m, input bit i, input bit d, input bit t);
    mode_pulse = m; inc_pulse = i; dec_pulse = d; tick_1hz = t;
    @(posedge clk);
    model_edge(m, i, d, t);
    #1;
    compare_all();
    mode_pulse = 0; inc_pulse = 0; dec_pulse = 0; tick_1hz = 0;
  endtask

  task automatic set_cur(input int h, input int mi, input int s);
    cur_hour = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_edit_active", edit_active, 0);
    chk("rst_edit_field", edit_field, 0);
    chk("rst_load", load_pulse, 0);
    chk("rst_blink", blink, 1);
    chk("rst_set_hour", set_hour, 0);
    chk("rst_set_min", set_min, 0);
    chk("rst_set_sec", set_sec, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_tmo = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // idle after reset with live time changing
    for (int k = 0; k < 10000; k++) begin
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      step(0, 0, 0, 0);
    end

    // capture, edit, commit
    set_cur(12, 34, 56);
    step(1, 0, 0, 0);
    chk("cap_field", edit_field, 1);
    chk("cap_hour", set_hour, 12);
    chk("cap_min", set_min, 34);
    chk("cap_sec", set_sec, 56);
    set_cur(1, 2, 3);
    step(1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    chk("commit_load", load_pulse, 1);
    chk("commit_active", edit_active, 0);
    chk("commit_hms", {set_hour, set_min, set_sec}, {5'd12, 6'd37, 6'd55});
    step(0, 0, 0, 0);
    chk("post_commit_load", load_pulse, 0);
    chk("post_commit_field", edit_field, 0);

    // wrap boundaries and simultaneous inc+dec
    set_cur(23, 0, 59);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); chk("hour_wrap_up", set_hour, 0);
    step(0, 0, 1, 0); chk("hour_wrap_dn", set_hour, 23);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); chk("min_wrap_dn", set_min, 59);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); chk("sec_wrap_up", set_sec, 0);
    step(0, 1, 1, 0); chk("incdec_same", set_sec, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // mode beats inc; then timeout in EDIT_M
    set_cur(5, 10, 20);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("mode_inc_field", edit_field, 2);
    chk("mode_inc_hour", set_hour, 5);
    step(0, 0, 0, 1); step(0, 0, 0, 0);
    step(0, 0, 0, 1); step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("timeout_exit", edit_active, 0);
    chk("timeout_noload", load_pulse, 0);
    step(0, 0, 0, 0);

    // key activity restarts the timeout
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("timeout_restart", edit_active, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // blink period and restart by inc
    step(1, 0, 0, 0);
    repeat (BH - 1) step(0, 0, 0, 0);
    chk("blink_hold", blink, 1);
    step(0, 0, 0, 0);
    chk("blink_toggle", blink, 0);
    repeat (500) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("blink_inc_force", blink, 1);
    repeat (BH - 1) step(0, 0, 0, 0);
    chk("blink_inc_hold", blink, 1);
    step(0, 0, 0, 0);
    chk("blink_inc_toggle", blink, 0);

    // reset mid-edit, asynchronous
    #3;
    do_reset();

    // random traffic
    for (int k = 0; k < 5000; k++) begin
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      step($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Consumes the single-cycle, debounced key pulses from the per-key debouncers and runs the digital clock's time-setting user interface. Holds shadow hour/minute/second registers and steps the edit field on each MODE press. Adjusts the selected field with INC/DEC presses. Issues a one-cycle load to the timekeeping counter on commit, and produces a blink enable for the display driver.

Parameters:
BLINK_HALF, 25_000_000, clk cycles per blink half-period (0.5 s at 50 MHz); bench uses 1_000.
TIMEOUT_SEC, 10, tick_1hz pulses without key activity before edit is abandoned; legal range 1..15.

Ports:
clk  in  1  50 MHz main clock
rst  in  1  reset; asynchronous, active-high
mode_pulse  in  1  one-cycle pulse, MODE key
inc_pulse  in  1  one-cycle pulse, INC key
dec_pulse  in  1  one-cycle pulse, DEC key
tick_1hz  in  1  one-cycle pulse once per second from the timebase
cur_hour  in  5  live hour, 0..23
cur_min  in  6  live minute, 0..59
cur_sec  in  6  live second, 0..59
edit_active  out  1  high in any EDIT state
edit_field  out  2  0=none, 1=hour, 2=min, 3=sec
set_hour  out  5  shadow hour
set_min  out  6  shadow minute
set_sec  out  6  shadow second
load_pulse  out  1  one-cycle commit strobe; set_* valid in the same cycle
blink  out  1  1 = show edited field, 0 = blank it

Behaviour:
- All outputs are registered. Reset values: edit_active=0, edit_field=0, set_*=0, load_pulse=0, blink=1. FSM resets to RUN. Reset mid-edit discards the shadow values and issues no load.
- States and encodings: RUN (edit_field=0), EDIT_H (1), EDIT_M (2), EDIT_S (3), COMMIT.
- RUN + mode_pulse: capture cur_hour/cur_min/cur_sec into set_*, go to EDIT_H. Outputs change on the next clock edge (1-cycle latency).
- EDIT_H + mode -> EDIT_M; EDIT_M + mode -> EDIT_S; EDIT_S + mode -> COMMIT.
- COMMIT: load_pulse=1 for exactly one cycle with edit_active=0 and edit_field=0; the next state is RUN unconditionally. Key pulses arriving in COMMIT are ignored.
- inc/dec in EDIT_x adjusts only the selected field, with a 1-cycle latency:
  - hour wraps 23<->0.
  - min and sec wrap 59<->0.
  - Arithmetic is compare-and-wrap at field width; no modulo operator.
- inc and dec in the same cycle: no change, but this still counts as key activity.
- mode together with inc or dec in the same cycle: mode wins; the adjustment is dropped.
- inc/dec in RUN: ignored.
- Timeout counter:
  - cleared on entering edit and on any key pulse.
  - incremented on each tick_1hz while in edit.
  - on reaching TIMEOUT_SEC: return to RUN, no load_pulse, set_* hold their last values.
  - tick_1hz coinciding with a key pulse: the key wins and the counter clears.
- Blink:
  - forced to 1 outside edit.
  - on entering edit and on any inc/dec: blink=1 and the blink counter clears.
  - otherwise toggles every BLINK_HALF cycles; the counter wraps at BLINK_HALF-1.
- set_* are stable outside edit, holding the last captured or edited values.

Decomposition:
- Package clock_pkg:
  - state enum (RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT).
  - field codes FIELD_NONE/HOUR/MIN/SEC.
  - HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - field widths 5/6/6.
- One sub-module, blink_gen: inputs clk, rst, en, restart; parameter BLINK_HALF; output blink. It holds the blink counter and toggle flop.
- The FSM, shadow registers, wrap arithmetic and timeout counter stay in time_set_ctrl.

Test Plan:
- Reset then release, no keys -> edit_active=0, edit_field=0, blink=1, load_pulse never asserted over 10k cycles.
- cur=12:34:56, mode -> next cycle edit_field=1, set_*=12:34:56; then mode, inc x3, mode, dec, mode -> exactly one load_pulse with set=12:37:55, then edit_field=0.
- Wrap: in EDIT_H with hour=23, inc -> 0, dec -> 23. In EDIT_M with min=0, dec -> 59. In EDIT_S with sec=59, inc -> 0.
- Simultaneous events:
  - inc+dec in the same cycle -> field unchanged.
  - mode+inc in EDIT_H -> edit_field=2 and hour unchanged.
- Timeout with TIMEOUT_SEC=3, in EDIT_M:
  - 3 tick_1hz pulses with no keys -> edit_active=0 and no load_pulse.
  - Repeat with an inc between tick 2 and tick 3 -> still in edit after the 3rd tick.
- Blink with BLINK_HALF=1000:
  - in edit, blink toggles every 1000 cycles.
  - an inc mid-period forces blink=1 and restarts the period.
  - rst asserted mid-edit -> all outputs return to reset values asynchronously.
